// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and constants for the data-memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int WORD_STEP    = 4;
    localparam int DEF_LEN_W    = 4;
    localparam int DEF_MAX_WAIT = 3;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : CPU, DMA and pipe_mem buses of the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = DEF_LEN_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_w;
    logic              cpu_h;
    logic              cpu_b;
    logic              cpu_z;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;
    logic              cpu_aerr;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]  dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_accept;
    logic              dma_err;
    logic              dma_beat;
    logic              dma_done;
    logic              dma_busy;

    logic              mem_w;
    logic              mem_h;
    logic              mem_b;
    logic              mem_z;
    logic              mem_ena;
    logic              mem_wena;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_aerr;

    // Arbiter side: masters pipe_mem, answers both requesters.
    modport master (
        input  cpu_req, cpu_we, cpu_w, cpu_h, cpu_b, cpu_z, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall, cpu_aerr,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output dma_rdata, dma_accept, dma_err, dma_beat, dma_done, dma_busy,
        output mem_w, mem_h, mem_b, mem_z, mem_ena, mem_wena, mem_addr, mem_wdata,
        input  mem_rdata, mem_aerr
    );

    modport slave (
        output cpu_req, cpu_we, cpu_w, cpu_h, cpu_b, cpu_z, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall, cpu_aerr,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  dma_rdata, dma_accept, dma_err, dma_beat, dma_done, dma_busy,
        input  mem_w, mem_h, mem_b, mem_z, mem_ena, mem_wena, mem_addr, mem_wdata,
        output mem_rdata, mem_aerr
    );

endinterface

`default_nettype wire

// File: rtl/dmem_burst_ctr.sv
// ============================================================================
// Module   : dmem_burst_ctr
// Purpose  : DMA burst address register and remaining-beat down-counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_burst_ctr
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_step,
    input  wire logic [ADDR_W-1:0] i_load_addr,
    input  wire logic [LEN_W-1:0]  i_load_len,
    output logic      [ADDR_W-1:0] o_addr,
    output logic                   o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remain;

    // Address wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_addr   <= i_load_addr;
            r_remain <= i_load_len;
        end else if (i_step) begin
            r_addr <= r_addr + ADDR_W'(WORD_STEP);
            if (r_remain != '0) begin
                r_remain <= r_remain - LEN_W'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remain == '0);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares pipe_mem between the MEM stage (priority) and a DMA burst
//            engine, with a starvation limit. Define DMEM_ARB_STATS_EN to add
//            saturating stall/beat statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dmem_arbiter_if.master   bus,
    output logic [15:0]      stat_stall_cyc,
    output logic [15:0]      stat_dma_beats
);

    localparam int                WAIT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_dir;
    logic              w_dir_nxt;

    logic              w_busy;
    logic              w_aligned;
    logic              w_cpu_grant;
    logic              w_beat;
    logic              w_accept;
    logic              w_reject;
    logic              w_ctr_load;
    logic              w_ctr_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_burst_addr;

    // CPU wins unless a pending DMA beat has already waited MAX_WAIT grants.
    assign w_busy      = (r_state == BUSY);
    assign w_aligned   = (bus.dma_addr[1:0] == 2'b00);
    assign w_cpu_grant = bus.cpu_req & (~w_busy | (r_wait_cnt < C_MAX_WAIT));
    assign w_beat      = w_busy & ~w_cpu_grant;
    assign w_accept    = ~w_busy & bus.dma_req & w_aligned;
    assign w_reject    = ~w_busy & bus.dma_req & ~w_aligned;

    dmem_burst_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_ctr_load),
        .i_step      (w_ctr_step),
        .i_load_addr (bus.dma_addr),
        .i_load_len  (bus.dma_len),
        .o_addr      (w_burst_addr),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_dir      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_dir      <= w_dir_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_nxt     = r_wait_cnt;
        w_dir_nxt      = r_dir;
        w_ctr_load     = 1'b0;
        w_ctr_step     = 1'b0;
        bus.cpu_rdata  = '0;
        bus.cpu_ack    = 1'b0;
        bus.cpu_stall  = 1'b0;
        bus.cpu_aerr   = 1'b0;
        bus.dma_rdata  = '0;
        bus.dma_accept = 1'b0;
        bus.dma_err    = 1'b0;
        bus.dma_beat   = 1'b0;
        bus.dma_done   = 1'b0;
        bus.dma_busy   = 1'b0;
        bus.mem_w      = 1'b0;
        bus.mem_h      = 1'b0;
        bus.mem_b      = 1'b0;
        bus.mem_z      = 1'b0;
        bus.mem_ena    = 1'b0;
        bus.mem_wena   = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = BUSY;
                    w_ctr_load  = 1'b1;
                    w_wait_nxt  = '0;
                    w_dir_nxt   = bus.dma_we;
                end
            end
            BUSY: begin
                if (w_cpu_grant) begin
                    w_wait_nxt = r_wait_cnt + WAIT_W'(1);
                end else begin
                    w_ctr_step = 1'b1;
                    w_wait_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Every output is held low while reset is asserted.
        if (!rst) begin
            bus.cpu_ack    = w_cpu_grant;
            bus.cpu_stall  = bus.cpu_req & ~w_cpu_grant;
            bus.cpu_rdata  = w_cpu_grant ? bus.mem_rdata : '0;
            bus.cpu_aerr   = bus.mem_aerr & w_cpu_grant;
            bus.dma_accept = w_accept;
            bus.dma_err    = w_reject;
            bus.dma_beat   = w_beat;
            bus.dma_done   = w_beat & w_last;
            bus.dma_busy   = w_busy;
            bus.dma_rdata  = w_beat ? bus.mem_rdata : '0;
            bus.mem_ena    = w_cpu_grant | w_beat;
            if (w_beat) begin
                bus.mem_w     = 1'b1;
                bus.mem_wena  = r_dir;
                bus.mem_addr  = w_burst_addr;
                bus.mem_wdata = bus.dma_wdata;
            end else begin
                bus.mem_w     = bus.cpu_w;
                bus.mem_h     = bus.cpu_h;
                bus.mem_b     = bus.cpu_b;
                bus.mem_z     = bus.cpu_z;
                bus.mem_wena  = bus.cpu_we & w_cpu_grant;
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic        w_stall;
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_beats;

    assign w_stall = bus.cpu_req & ~w_cpu_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_stall <= '0;
            r_stat_beats <= '0;
        end else begin
            if (w_stall && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
            if (w_beat && (r_stat_beats != 16'hFFFF)) begin
                r_stat_beats <= r_stat_beats + 16'd1;
            end
        end
    end

    assign stat_stall_cyc = r_stat_stall;
    assign stat_dma_beats = r_stat_beats;
`else
    assign stat_stall_cyc = 16'h0000;
    assign stat_dma_beats = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed-vector bench for dmem_arbiter with a pipe_mem model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stat_stall_cyc;
    logic [15:0] stat_dma_beats;
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

    dmem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .LEN_W    (4),
        .MAX_WAIT (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master),
        .stat_stall_cyc (stat_stall_cyc),
        .stat_dma_beats (stat_dma_beats)
    );

    // pipe_mem model: little-endian, combinational read, sized/extended lanes.
    logic [31:0] mem_arr [256];
    logic [7:0]  m_idx;
    logic [4:0]  m_sh;
    logic [31:0] m_word, m_lane, m_rd, m_merged;
    logic        m_aerr;

    always_comb begin
        m_idx    = bus.mem_addr[9:2];
        m_sh     = {bus.mem_addr[1:0], 3'b000};
        m_word   = mem_arr[m_idx];
        m_lane   = m_word >> m_sh;
        m_aerr   = (bus.mem_w && (bus.mem_addr[1:0] != 2'b00)) || (bus.mem_h && bus.mem_addr[0]);
        m_rd     = 32'h0;
        m_merged = m_word;
        if (bus.mem_w) begin
            m_rd     = m_word;
            m_merged = bus.mem_wdata;
        end else if (bus.mem_h) begin
            m_rd     = bus.mem_z ? {16'h0, m_lane[15:0]} : {{16{m_lane[15]}}, m_lane[15:0]};
            m_merged = (m_word & ~(32'h0000FFFF << m_sh)) | ({16'h0, bus.mem_wdata[15:0]} << m_sh);
        end else if (bus.mem_b) begin
            m_rd     = bus.mem_z ? {24'h0, m_lane[7:0]} : {{24{m_lane[7]}}, m_lane[7:0]};
            m_merged = (m_word & ~(32'h000000FF << m_sh)) | ({24'h0, bus.mem_wdata[7:0]} << m_sh);
        end
    end

    assign bus.mem_rdata = m_rd;
    assign bus.mem_aerr  = m_aerr;

    always @(posedge clk) begin
        if (bus.mem_ena && bus.mem_wena && !m_aerr) mem_arr[m_idx] <= m_merged;
    end

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_w = 0; bus.cpu_h = 0;
        bus.cpu_b = 0; bus.cpu_z = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_len = 0;
        bus.dma_wdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst = 1'b1;
        idle_inputs();
        bus.cpu_req = 1; bus.cpu_w = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h4;
        bus.dma_req = 1; bus.dma_addr = 32'h40;
        @(negedge clk);
        got = {bus.mem_ena, bus.mem_w, bus.mem_wena, bus.cpu_ack,
               bus.cpu_stall, bus.dma_accept, bus.dma_busy, bus.dma_beat};
        vectors++;
        if (got !== 8'h00) begin
            miscompares++; $display("FAIL reset_ctl: got %b want 00000000", got);
        end
        vectors++;
        if (bus.mem_addr !== 32'h0 || bus.cpu_rdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_data: addr %h rdata %h want 0", bus.mem_addr, bus.cpu_rdata);
        end
        idle_inputs();
        step();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.dma_busy, bus.mem_ena, bus.dma_err} !== 3'b000) begin
            miscompares++; $display("FAIL reset_release: got %b want 000", {bus.dma_busy, bus.mem_ena, bus.dma_err});
        end
        step();
    endtask

    task automatic test_cpu_only();
        bus.cpu_req = 1; bus.cpu_b = 1; bus.cpu_we = 1;
        bus.cpu_addr = 32'h13; bus.cpu_wdata = 32'hAB;
        @(negedge clk);
        vectors++;
        if ({bus.mem_ena, bus.mem_b, bus.mem_w, bus.mem_wena, bus.cpu_ack, bus.cpu_stall} !== 6'b110110) begin
            miscompares++; $display("FAIL cpu_wr_ctl: got %b want 110110",
                {bus.mem_ena, bus.mem_b, bus.mem_w, bus.mem_wena, bus.cpu_ack, bus.cpu_stall});
        end
        vectors++;
        if (bus.mem_addr !== 32'h13 || bus.mem_wdata !== 32'hAB) begin
            miscompares++; $display("FAIL cpu_wr_bus: addr %h wdata %h want 13 ab", bus.mem_addr, bus.mem_wdata);
        end
        step();
        bus.cpu_we = 0; bus.cpu_z = 0;
        @(negedge clk);
        vectors++;
        if (bus.cpu_rdata !== 32'hFFFFFFAB) begin
            miscompares++; $display("FAIL cpu_rd_sext: got %h want ffffffab", bus.cpu_rdata);
        end
        step();
        bus.cpu_z = 1;
        @(negedge clk);
        vectors++;
        if (bus.cpu_rdata !== 32'h000000AB || bus.mem_wena !== 1'b0) begin
            miscompares++; $display("FAIL cpu_rd_zext: got %h wena %b want 000000ab 0", bus.cpu_rdata, bus.mem_wena);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_dma_write();
        logic [5:0] exp;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h40; bus.dma_len = 4'd3;
        @(negedge clk);
        vectors++;
        if ({bus.dma_accept, bus.dma_beat, bus.dma_busy, bus.mem_ena, bus.dma_err} !== 5'b10000) begin
            miscompares++; $display("FAIL dma_accept: got %b want 10000",
                {bus.dma_accept, bus.dma_beat, bus.dma_busy, bus.mem_ena, bus.dma_err});
        end
        step();
        bus.dma_req = 0;
        for (int i = 0; i < 4; i++) begin
            bus.dma_wdata = 32'h1000 + i;
            @(negedge clk);
            exp = {1'b1, 1'b1, (i == 3), 1'b1, 1'b1, 1'b1};
            vectors++;
            if ({bus.dma_beat, bus.dma_busy, bus.dma_done, bus.mem_ena, bus.mem_wena, bus.mem_w} !== exp) begin
                miscompares++; $display("FAIL dma_wr_beat%0d: got %b want %b", i,
                    {bus.dma_beat, bus.dma_busy, bus.dma_done, bus.mem_ena, bus.mem_wena, bus.mem_w}, exp);
            end
            vectors++;
            if (bus.mem_addr !== 32'h40 + 4 * i) begin
                miscompares++; $display("FAIL dma_wr_addr%0d: got %h want %h", i, bus.mem_addr, 32'h40 + 4 * i);
            end
            step();
        end
        bus.cpu_req = 1; bus.cpu_w = 1; bus.cpu_addr = 32'h44;
        @(negedge clk);
        vectors++;
        if ({bus.dma_busy, bus.dma_beat, bus.cpu_ack} !== 3'b001 || bus.cpu_rdata !== 32'h1001) begin
            miscompares++; $display("FAIL dma_wr_after: flags %b rdata %h want 001 00001001",
                {bus.dma_busy, bus.dma_beat, bus.cpu_ack}, bus.cpu_rdata);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic       b;
        logic [4:0] exp;
        bus.cpu_req = 1; bus.cpu_w = 1; bus.cpu_addr = 32'h48;
        bus.dma_req = 1; bus.dma_we = 0; bus.dma_addr = 32'h40; bus.dma_len = 4'd1;
        @(negedge clk);
        vectors++;
        if ({bus.dma_accept, bus.cpu_ack, bus.cpu_stall} !== 3'b110) begin
            miscompares++; $display("FAIL starve_accept: got %b want 110", {bus.dma_accept, bus.cpu_ack, bus.cpu_stall});
        end
        step();
        bus.dma_req = 0;
        for (int i = 0; i < 8; i++) begin
            b = ((i % 4) == 3);
            exp = {~b, b, b, (i == 7), 1'b1};
            @(negedge clk);
            vectors++;
            if ({bus.cpu_ack, bus.cpu_stall, bus.dma_beat, bus.dma_done, bus.dma_busy} !== exp) begin
                miscompares++; $display("FAIL starve_cyc%0d: got %b want %b", i,
                    {bus.cpu_ack, bus.cpu_stall, bus.dma_beat, bus.dma_done, bus.dma_busy}, exp);
            end
            vectors++;
            if (b && (bus.dma_rdata !== 32'h1000 + i / 4 || bus.cpu_rdata !== 32'h0)) begin
                miscompares++; $display("FAIL starve_dma_rd%0d: dma %h cpu %h want %h 0", i,
                    bus.dma_rdata, bus.cpu_rdata, 32'h1000 + i / 4);
            end else if (!b && bus.cpu_rdata !== 32'h1002) begin
                miscompares++; $display("FAIL starve_cpu_rd%0d: got %h want 00001002", i, bus.cpu_rdata);
            end
            step();
        end
        @(negedge clk);
        vectors++;
        if ({bus.dma_busy, bus.cpu_ack, bus.cpu_stall} !== 3'b010) begin
            miscompares++; $display("FAIL starve_end: got %b want 010", {bus.dma_busy, bus.cpu_ack, bus.cpu_stall});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_misaligned();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h42; bus.dma_len = 4'd2;
        @(negedge clk);
        vectors++;
        if ({bus.dma_err, bus.dma_accept, bus.dma_busy} !== 3'b100) begin
            miscompares++; $display("FAIL misalign_err: got %b want 100", {bus.dma_err, bus.dma_accept, bus.dma_busy});
        end
        step();
        bus.dma_req = 0;
        @(negedge clk);
        vectors++;
        if ({bus.dma_err, bus.dma_busy, bus.dma_beat} !== 3'b000) begin
            miscompares++; $display("FAIL misalign_after: got %b want 000", {bus.dma_err, bus.dma_busy, bus.dma_beat});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr;
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'hFFFFFFFC; bus.dma_len = 4'd1;
        step();
        bus.dma_req = 0;
        for (int i = 0; i < 2; i++) begin
            bus.dma_wdata = 32'h5A00 + i;
            exp_addr = (i == 0) ? 32'hFFFFFFFC : 32'h0;
            @(negedge clk);
            vectors++;
            if (bus.mem_addr !== exp_addr || {bus.dma_beat, bus.dma_done} !== {1'b1, (i == 1)}) begin
                miscompares++; $display("FAIL wrap_beat%0d: addr %h beat/done %b want %h 1%0d", i,
                    bus.mem_addr, {bus.dma_beat, bus.dma_done}, exp_addr, (i == 1));
            end
            step();
        end
        @(negedge clk);
        vectors++;
        if (bus.dma_busy !== 1'b0) begin
            miscompares++; $display("FAIL wrap_idle: busy %b want 0", bus.dma_busy);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_burst();
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 32'h80; bus.dma_len = 4'd7;
        step();
        bus.dma_req = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.dma_beat !== 1'b1 || bus.mem_addr !== 32'h80 + 4 * i) begin
                miscompares++; $display("FAIL rstmid_beat%0d: beat %b addr %h want 1 %h", i,
                    bus.dma_beat, bus.mem_addr, 32'h80 + 4 * i);
            end
            step();
        end
        bus.cpu_req = 1; bus.cpu_w = 1; bus.cpu_addr = 32'h10;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.dma_busy, bus.dma_beat, bus.dma_done, bus.mem_ena, bus.cpu_ack, bus.cpu_stall} !== 6'b0) begin
            miscompares++; $display("FAIL rstmid_hold: got %b want 000000",
                {bus.dma_busy, bus.dma_beat, bus.dma_done, bus.mem_ena, bus.cpu_ack, bus.cpu_stall});
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.dma_busy, bus.cpu_ack, bus.mem_ena, bus.dma_beat} !== 4'b0110 || bus.cpu_rdata !== 32'hAB000000) begin
            miscompares++; $display("FAIL rstmid_idle: flags %b rdata %h want 0110 ab000000",
                {bus.dma_busy, bus.cpu_ack, bus.mem_ena, bus.dma_beat}, bus.cpu_rdata);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_cpu_aerr();
        bus.cpu_req = 1; bus.cpu_w = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h11223344;
        @(negedge clk);
        vectors++;
        if ({bus.cpu_aerr, bus.cpu_ack} !== 2'b01) begin
            miscompares++; $display("FAIL aerr_clean: got %b want 01", {bus.cpu_aerr, bus.cpu_ack});
        end
        step();
        bus.cpu_addr = 32'h2; bus.cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++;
        if ({bus.cpu_aerr, bus.mem_ena, bus.cpu_ack} !== 3'b111) begin
            miscompares++; $display("FAIL aerr_fwd: got %b want 111", {bus.cpu_aerr, bus.mem_ena, bus.cpu_ack});
        end
        step();
        bus.cpu_we = 0; bus.cpu_addr = 32'h0;
        @(negedge clk);
        vectors++;
        if (bus.cpu_rdata !== 32'h11223344 || bus.cpu_aerr !== 1'b0) begin
            miscompares++; $display("FAIL aerr_nowrite: rdata %h aerr %b want 11223344 0", bus.cpu_rdata, bus.cpu_aerr);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_only();
        test_dma_write();
        test_starvation();
        test_misaligned();
        test_wrap();
        test_reset_mid_burst();
        test_cpu_aerr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
